// File: rtl/crc_check.sv
// Serial frame receiver: 32 data bits then 16 CRC bits (CCITT 0x1021, init 0).
// Define CRC_CHECK_ERR_CNT_EN to build the saturating bad-frame counter.
module crc_check (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        serial_in,
  output logic [31:0] data_out,
  output logic [15:0] crc_rx,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        done_tick,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] eng_q, eng_d;
  logic [31:0] dsh_q, dsh_d;
  logic [15:0] rsh_q, rsh_d;
  logic [31:0] dout_q, dout_d;
  logic [15:0] crx_q, crx_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        consume;
  logic        fb;
  logic        fin;
  logic        match;

  assign consume = enable & ((state_q == DATA) | (state_q == CRC));
  assign fb      = eng_q[15] ^ serial_in;
  assign match   = (eng_q == {rsh_q[14:0], serial_in});
  // frame_start wins over completion on the 48th bit
  assign fin     = consume & (state_q == CRC) & (cnt_q == 6'd47)
                 & ~frame_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eng_d   = eng_q;
    dsh_d   = dsh_q;
    rsh_d   = rsh_q;
    dout_d  = dout_q;
    crx_d   = crx_q;
    ok_d    = ok_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: ;
      DATA: begin
        if (consume) begin
          dsh_d = {dsh_q[30:0], serial_in};
          eng_d = {eng_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = CRC;
        end
      end
      CRC: begin
        if (consume) begin
          rsh_d = {rsh_q[14:0], serial_in};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd47) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      dout_d = dsh_q;
      crx_d  = {rsh_q[14:0], serial_in};
      ok_d   = match;
      err_d  = ~match;
    end
    if (frame_start) begin
      state_d = DATA;
      cnt_d   = 6'd0;
      eng_d   = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      eng_q   <= 16'h0000;
      dsh_q   <= 32'h0;
      rsh_q   <= 16'h0000;
      dout_q  <= 32'h0;
      crx_q   <= 16'h0000;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eng_q   <= eng_d;
      dsh_q   <= dsh_d;
      rsh_q   <= rsh_d;
      dout_q  <= dout_d;
      crx_q   <= crx_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

`ifdef CRC_CHECK_ERR_CNT_EN
  logic [7:0] ec_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      ec_q <= 8'h00;
    end else if (fin && !match && ec_q != 8'hFF) begin
      ec_q <= ec_q + 8'd1;
    end
  end

  assign err_count = ec_q;
`else
  assign err_count = 8'h00;
`endif

  assign data_out  = dout_q;
  assign crc_rx    = crx_q;
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign done_tick = (state_q == DONE);
  assign busy      = (state_q == DATA) | (state_q == CRC);

endmodule

// File: tb/tb_crc_check.sv
// Scoreboarded bench for crc_check: expected frames queued on send,
// popped and compared when done_tick fires.
`timescale 1ns/1ps
module tb_crc_check;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        serial_in = 1'b0;
  logic [31:0] data_out;
  logic [15:0] crc_rx;
  logic        crc_ok;
  logic        crc_err;
  logic        done_tick;
  logic        busy;
  logic [7:0]  err_count;

  typedef struct {
    logic [31:0] d;
    logic [15:0] c;
    logic        ok;
    logic [7:0]  ec;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_ec = 8'h00;

  crc_check dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .frame_start(frame_start),
    .serial_in(serial_in),
    .data_out(data_out),
    .crc_rx(crc_rx),
    .crc_ok(crc_ok),
    .crc_err(crc_err),
    .done_tick(done_tick),
    .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc16(input logic [31:0] d);
    logic [15:0] c;
    logic        f;
    c = 16'h0000;
    for (int i = 31; i >= 0; i--) begin
      f = c[15] ^ d[i];
      c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always @(negedge clk) begin
    checks++;
    if (crc_ok && crc_err) begin
      errors++;
      $display("FAIL ok_err_exclusive: ok=%b err=%b required not both 1",
               crc_ok, crc_err);
    end
    if (done_tick) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done_tick=1 required 0 (no frame due)");
      end else begin
        e = sb.pop_front();
        if (data_out !== e.d || crc_rx !== e.c || crc_ok !== e.ok ||
            crc_err !== !e.ok || err_count !== e.ec) begin
          errors++;
          $display("FAIL frame_result: got d=%h c=%h ok=%b err=%b ec=%h required d=%h c=%h ok=%b err=%b ec=%h",
                   data_out, crc_rx, crc_ok, crc_err, err_count,
                   e.d, e.c, e.ok, !e.ok, e.ec);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn        = 1'b1;
    frame_start = 1'b1;
    enable      = 1'b1;
    serial_in   = 1'b1;
    step();
    rstn        = 1'b0;
    frame_start = 1'b0;
    enable      = 1'b0;
    serial_in   = 1'b0;
    m_ec        = 8'h00;
  endtask

  task automatic run_frame(input logic [31:0] d, input logic [15:0] c,
                           input bit tog, input bit skip_fs);
    logic [47:0] w;
    bit          good;
    w    = {d, c};
    good = (crc16(d) == c);
`ifdef CRC_CHECK_ERR_CNT_EN
    if (!good && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
`endif
    sb.push_back('{d: d, c: c, ok: good, ec: m_ec});
    if (!skip_fs) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    for (int i = 47; i >= 0; i--) begin
      serial_in = w[i];
      enable    = 1'b1;
      step();
      if (i != 0) begin
        checks++;
        if (busy !== 1'b1 || done_tick !== 1'b0) begin
          errors++;
          $display("FAIL in_frame: busy=%b done=%b required busy=1 done=0 bit=%0d",
                   busy, done_tick, i);
        end
        if (tog) begin
          enable = 1'b0;
          step();
          checks++;
          if (busy !== 1'b1 || done_tick !== 1'b0) begin
            errors++;
            $display("FAIL stall: busy=%b done=%b required busy=1 done=0 bit=%0d",
                     busy, done_tick, i);
          end
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (done_tick !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_latency: done=%b busy=%b required done=1 busy=0",
               done_tick, busy);
    end
    step();
    checks++;
    if (done_tick !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: done=%b busy=%b required 0 0",
               done_tick, busy);
    end
  endtask

  task automatic send_partial(input logic [47:0] w, input int nbits);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      serial_in = w[47-k];
      enable    = 1'b1;
      step();
    end
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (data_out !== 32'h0 || crc_rx !== 16'h0 || crc_ok !== 1'b0 ||
        crc_err !== 1'b0 || done_tick !== 1'b0 || busy !== 1'b0 ||
        err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: d=%h c=%h ok=%b err=%b done=%b busy=%b ec=%h required all 0",
               data_out, crc_rx, crc_ok, crc_err, done_tick, busy, err_count);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_zero_frame();
    run_frame(32'h0000_0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_good_bad();
    run_frame(32'h0000_0001, 16'h1021, 1'b0, 1'b0);
    run_frame(32'h0000_0001, 16'h1020, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [15:0] c;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      c = crc16(d);
      if (i % 2 == 1) c = c ^ (16'h0001 << i);
      run_frame(d, c, 1'b0, 1'b0);
    end
  endtask

  task automatic test_enable_toggle();
    run_frame(32'h0000_0001, 16'h1021, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    send_partial({32'h0000_0001, 16'h1021}, 20);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    m_ec = 8'h00;
    checks++;
    if (busy !== 1'b0 || data_out !== 32'h0 || crc_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b d=%h ok=%b required 0 0 0",
               busy, data_out, crc_ok);
    end
    step();
    run_frame(32'h0000_0001, 16'h1021, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    send_partial({32'hDEAD_BEEF, 16'h1234}, 40);
    run_frame(32'hCAFE_F00D, crc16(32'hCAFE_F00D), 1'b0, 1'b0);
  endtask

  task automatic test_last_bit_abort();
    logic [47:0] w;
    w = {32'h1234_5678, crc16(32'h1234_5678)};
    send_partial(w, 47);
    serial_in   = w[0];
    enable      = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    enable      = 1'b0;
    checks++;
    if (done_tick !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL last_bit_abort: done=%b busy=%b required done=0 busy=1",
               done_tick, busy);
    end
    run_frame(32'h8000_0000, crc16(32'h8000_0000), 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    logic [7:0]  want;
    for (int i = 0; i < 260; i++) begin
      d = $urandom;
      run_frame(d, crc16(d) ^ 16'h0001, 1'b0, 1'b0);
    end
`ifdef CRC_CHECK_ERR_CNT_EN
    want = 8'hFF;
`else
    want = 8'h00;
`endif
    checks++;
    if (err_count !== want) begin
      errors++;
      $display("FAIL err_count_sat: got %h required %h", err_count, want);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_frame();
    test_good_bad();
    test_random();
    test_enable_toggle();
    test_reset_abort();
    test_restart();
    test_last_bit_abort();
    test_saturate();
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_done: %0d frames pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
